// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b with borrow-out, one bit per clock.
// Optional SERIAL_SUBTRACTOR_SAT_EN clamps diff to zero when the final borrow is set.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, d_sh;
    logic [CNT_W-1:0] cnt;
    logic             brw;

    logic             load, step, last_bit;
    logic             d_bit, brw_nxt;
    logic [WIDTH-1:0] d_sh_nxt;

    // Full subtractor: half-subtractor core on a_sh[0]/b_sh[0] plus the borrow flop
    always_comb begin
        d_bit    = a_sh[0] ^ b_sh[0] ^ brw;
        brw_nxt  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
        d_sh_nxt = {d_bit, d_sh[WIDTH-1:1]};
        last_bit = (cnt == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            d_sh <= '0;
            cnt  <= '0;
            brw  <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
        end else if (load) begin
            a_sh <= a;
            b_sh <= b;
            d_sh <= '0;
            cnt  <= '0;
            brw  <= 1'b0;
        end else if (step) begin
            a_sh <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh <= {1'b0, b_sh[WIDTH-1:1]};
            d_sh <= d_sh_nxt;
            brw  <= brw_nxt;
            if (last_bit) begin
                // Result registers update only here, so shifting state never leaks out
`ifdef SERIAL_SUBTRACTOR_SAT_EN
                diff <= brw_nxt ? '0 : d_sh_nxt;
`else
                diff <= d_sh_nxt;
`endif
                bout <= brw_nxt;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): stimulus pushes expected results,
// a negedge monitor pops them on done and checks busy/done timing and held outputs.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, bout;
    logic [WIDTH-1:0] diff;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bo;
        int               acc;
        int               due;
    } exp_t;

    exp_t             q[$];
    int               cyc = 0;
    int               n_chk = 0;
    int               n_pass = 0;
    logic [WIDTH-1:0] held_d = '0;
    logic             held_b = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [WIDTH-1:0] exp_diff(input logic [WIDTH-1:0] d, input logic bo);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
        return bo ? '0 : d;
`else
        return d;
`endif
    endfunction

    // Called at posedge+1; the following edge is the accepting one
    task automatic push_exp(input logic [WIDTH-1:0] d, input logic bo);
        exp_t e;
        e.d   = exp_diff(d, bo);
        e.bo  = bo;
        e.acc = cyc + 1;
        e.due = cyc + 1 + WIDTH;
        q.push_back(e);
    endtask

    task automatic issue(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic [WIDTH-1:0] d, input logic bo);
        start = 1'b1;
        a     = va;
        b     = vb;
        push_exp(d, bo);
        @(posedge clk); #1;
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4 * WIDTH && q.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        check(name, q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            held_d = '0;
            held_b = 1'b0;
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_diff", diff, 0);
            check("rst_bout", bout, 0);
        end else if (q.size() == 0) begin
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
        end else begin
            check("busy", busy, (cyc >= q[0].acc && cyc < q[0].due));
            if (cyc >= q[0].due) begin
                check("done_pulse", done, 1);
                if (done) begin
                    check("diff", diff, q[0].d);
                    check("bout", bout, q[0].bo);
                    held_d = q[0].d;
                    held_b = q[0].bo;
                end
                void'(q.pop_front());
            end else begin
                check("done_early", done, 0);
            end
        end
        if (rst_n && !done) begin
            check("diff_hold", diff, held_d);
            check("bout_hold", bout, held_b);
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("por_busy", busy, 0);
        check("por_done", done, 0);
        check("por_diff", diff, 0);
        check("por_bout", bout, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        issue(8'h05, 8'h03, 8'h02, 1'b0);
        drain("drain_05_03");
        issue(8'h03, 8'h05, 8'hFE, 1'b1);
        drain("drain_03_05");
        issue(8'h00, 8'h01, 8'hFF, 1'b1);
        drain("drain_00_01");
        issue(8'hFF, 8'hFF, 8'h00, 1'b0);
        drain("drain_FF_FF");

        // start held high; operands change every cycle, only accepting edges matter
        for (int k = 0; k < 3 * (WIDTH + 1); k++) begin
            start = 1'b1;
            if (k == 0) begin
                a = 8'h80; b = 8'h01; push_exp(8'h7F, 1'b0);
            end else if (k == WIDTH + 1) begin
                a = 8'h10; b = 8'h20; push_exp(8'hF0, 1'b1);
            end else if (k == 2 * (WIDTH + 1)) begin
                a = 8'hC3; b = 8'h3C; push_exp(8'h87, 1'b0);
            end else begin
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        drain("drain_stream");

        // Reset during the fourth RUN cycle: outputs clear at once, no done follows
        issue(8'hA5, 8'h5A, 8'h4B, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_diff", diff, 0);
        check("async_bout", bout, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2 * WIDTH) @(posedge clk);
        #1;
        issue(8'hA5, 8'h5A, 8'h4B, 1'b0);
        drain("drain_A5_5A");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
